// File: rtl/run_ctrl_if.sv
// Run-control bus: CPU exception vector and debug command channel in,
// PC write gate, state, cause and counters out.
interface run_ctrl_if #(
   parameter int DATA_WIDTH = 64
);
   logic [7:0]            exception_i;
   logic                  cmd_valid_i;
   logic [1:0]            cmd_i;
   logic                  cmd_ready_o;
   logic                  pc_we_o;
   logic [2:0]            state_o;
   logic [7:0]            cause_o;
   logic [DATA_WIDTH-1:0] cycle_cnt_o;
   logic [DATA_WIDTH-1:0] instret_o;

   // Core/debugger side: drives exceptions and commands, observes status.
   modport master (
      output exception_i, cmd_valid_i, cmd_i,
      input  cmd_ready_o, pc_we_o, state_o, cause_o, cycle_cnt_o, instret_o
   );

   // Sequencer side.
   modport slave (
      input  exception_i, cmd_valid_i, cmd_i,
      output cmd_ready_o, pc_we_o, state_o, cause_o, cycle_cnt_o, instret_o
   );
endinterface

// File: rtl/run_ctrl.sv
// Run-control sequencer for the single-cycle RV64I core: gates PC writeback
// on exceptions and debug run/halt/step commands, latches the halt/error
// cause and keeps cycle / retired-instruction counters.
module run_ctrl #(
   parameter int DATA_WIDTH = 64,
   parameter int RST_HOLD   = 2
) (
   input logic      clk_i,
   input logic      rst_ni,
   run_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_NORMAL = 3'd1,
      ST_HALT   = 3'd2,
      ST_ERROR  = 3'd3,
      ST_STEP   = 3'd4
   } state_t;

   localparam logic [1:0] CMD_RUN  = 2'b01;
   localparam logic [1:0] CMD_HALT = 2'b10;
   localparam logic [1:0] CMD_STEP = 2'b11;

   localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

   state_t                state;
   logic [HOLD_W-1:0]     hold;
   logic [7:0]            cause;
   logic                  skip;
   logic [DATA_WIDTH-1:0] cycle_cnt;
   logic [DATA_WIDTH-1:0] instret;

   logic       fault;
   logic       trap;
   logic       ready;
   logic       accept;
   logic       pc_we;
   logic       resume_skip;
   logic [7:0] exc_cause;

   // Decoded exception classes; faults always outrank ECALL/EBREAK traps.
   assign fault     = |bus.exception_i[2:0];
   assign trap      = bus.exception_i[3] | bus.exception_i[4];
   assign exc_cause = bus.exception_i & 8'h1F;

   // Commands are only taken where the sequencer can act on them.
   assign ready  = (state == ST_NORMAL) || (state == ST_HALT);
   assign accept = bus.cmd_valid_i & ready;

   // A trap is masked for one PC-writing cycle after resuming from a trap halt.
   assign pc_we = ((state == ST_NORMAL) || (state == ST_STEP)) & ~fault & (~trap | skip);

   // Resuming past a latched ECALL/EBREAK must step over that instruction.
   assign resume_skip = cause[3] | cause[4];

   // Run-control FSM with the latched cause and trap-skip flag.
   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= ST_RST;
         hold  <= HOLD_INIT;
         cause <= 8'h00;
         skip  <= 1'b0;
      end else begin
         case (state)
            ST_RST: begin
               if (hold == '0) state <= ST_NORMAL;
               else            hold  <= hold - HOLD_W'(1);
            end
            ST_NORMAL: begin
               skip <= 1'b0;
               if (fault) begin
                  state <= ST_ERROR;
                  cause <= exc_cause;
               end else if (trap && !skip) begin
                  state <= ST_HALT;
                  cause <= exc_cause;
               end else if (accept && bus.cmd_i == CMD_HALT) begin
                  state <= ST_HALT;
                  cause <= 8'h80;
               end
            end
            ST_HALT: begin
               if (accept && bus.cmd_i == CMD_RUN) begin
                  state <= ST_NORMAL;
                  cause <= 8'h00;
                  skip  <= resume_skip;
               end else if (accept && bus.cmd_i == CMD_STEP) begin
                  state <= ST_STEP;
                  skip  <= resume_skip;
               end
            end
            ST_STEP: begin
               state <= ST_HALT;
               skip  <= 1'b0;
               cause <= (fault || (trap && !skip)) ? exc_cause : 8'h40;
            end
            ST_ERROR: begin
               state <= ST_ERROR;
            end
            default: begin
               state <= ST_ERROR;
            end
         endcase
      end
   end

   // Free-running cycle and retired-instruction counters, wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cycle_cnt <= '0;
         instret   <= '0;
      end else begin
         if (state != ST_RST) cycle_cnt <= cycle_cnt + DATA_WIDTH'(1);
         if (pc_we)           instret   <= instret + DATA_WIDTH'(1);
      end
   end

   assign bus.cmd_ready_o = ready;
   assign bus.pc_we_o     = pc_we;
   assign bus.state_o     = state;
   assign bus.cause_o     = cause;
   assign bus.cycle_cnt_o = cycle_cnt;
   assign bus.instret_o   = instret;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed testbench for run_ctrl: reset hold, trap halt/resume with skip,
// halt/step, fault stickiness, asynchronous reset mid-step, counter wrap.
module tb_run_ctrl;

   localparam int DW = 64;

   logic clk;
   logic rst_ni;
   int   compared;
   int   mismatched;
   longint unsigned exp_cycle;
   longint unsigned exp_instret;

   run_ctrl_if #(.DATA_WIDTH(DW)) bus ();

   run_ctrl #(.DATA_WIDTH(DW), .RST_HOLD(2)) dut (
      .clk_i  (clk),
      .rst_ni (rst_ni),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock edge, update the expected counters, then settle 1 time unit.
   task automatic tick(input bit we, input bit run);
      @(posedge clk);
      if (we)  exp_instret++;
      if (run) exp_cycle++;
      #1;
   endtask

   task automatic send(input logic valid, input logic [1:0] cmd);
      bus.cmd_valid_i = valid;
      bus.cmd_i       = cmd;
   endtask

   task automatic test_reset();
      rst_ni = 1'b1;
      #1 rst_ni = 1'b0;
      #1;
      compared++; if (bus.state_o !== 3'd0) begin mismatched++; $display("FAIL rst_state: got %0d want 0", bus.state_o); end
      compared++; if (bus.cause_o !== 8'h00) begin mismatched++; $display("FAIL rst_cause: got %h want 00", bus.cause_o); end
      compared++; if (bus.cycle_cnt_o !== 64'd0) begin mismatched++; $display("FAIL rst_cycle: got %0d want 0", bus.cycle_cnt_o); end
      compared++; if (bus.instret_o !== 64'd0) begin mismatched++; $display("FAIL rst_instret: got %0d want 0", bus.instret_o); end
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL rst_pc_we: got %b want 0", bus.pc_we_o); end
      compared++; if (bus.cmd_ready_o !== 1'b0) begin mismatched++; $display("FAIL rst_ready: got %b want 0", bus.cmd_ready_o); end
      @(negedge clk) rst_ni = 1'b1;
      exp_cycle = 0; exp_instret = 0;
      tick(0, 0);
      compared++; if (bus.state_o !== 3'd0) begin mismatched++; $display("FAIL hold1_state: got %0d want 0", bus.state_o); end
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL hold1_pc_we: got %b want 0", bus.pc_we_o); end
      tick(0, 0);
      compared++; if (bus.state_o !== 3'd1) begin mismatched++; $display("FAIL hold_exit_state: got %0d want 1", bus.state_o); end
      compared++; if (bus.pc_we_o !== 1'b1) begin mismatched++; $display("FAIL first_normal_pc_we: got %b want 1", bus.pc_we_o); end
      compared++; if (bus.cycle_cnt_o !== 64'd0) begin mismatched++; $display("FAIL rst_frozen_cycle: got %0d want 0", bus.cycle_cnt_o); end
      tick(1, 1);
      compared++; if (bus.instret_o !== 64'd1) begin mismatched++; $display("FAIL first_instret: got %0d want 1", bus.instret_o); end
      compared++; if (bus.cycle_cnt_o !== 64'd1) begin mismatched++; $display("FAIL first_cycle: got %0d want 1", bus.cycle_cnt_o); end
   endtask

   task automatic test_ebreak();
      bus.exception_i = 8'h10;
      #1;
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL ebreak_pc_we: got %b want 0", bus.pc_we_o); end
      tick(0, 1);
      compared++; if (bus.state_o !== 3'd2) begin mismatched++; $display("FAIL ebreak_state: got %0d want 2", bus.state_o); end
      compared++; if (bus.cause_o !== 8'h10) begin mismatched++; $display("FAIL ebreak_cause: got %h want 10", bus.cause_o); end
      send(1'b1, 2'b01);
      #1;
      compared++; if (bus.cmd_ready_o !== 1'b1) begin mismatched++; $display("FAIL halt_ready: got %b want 1", bus.cmd_ready_o); end
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL halt_pc_we: got %b want 0", bus.pc_we_o); end
      tick(0, 1);
      send(1'b0, 2'b00);
      compared++; if (bus.state_o !== 3'd1) begin mismatched++; $display("FAIL run_state: got %0d want 1", bus.state_o); end
      compared++; if (bus.cause_o !== 8'h00) begin mismatched++; $display("FAIL run_cause: got %h want 00", bus.cause_o); end
      #1;
      compared++; if (bus.pc_we_o !== 1'b1) begin mismatched++; $display("FAIL skip_pc_we: got %b want 1", bus.pc_we_o); end
      tick(1, 1);
      compared++; if (bus.state_o !== 3'd1) begin mismatched++; $display("FAIL skip_state: got %0d want 1", bus.state_o); end
      #1;
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL reebreak_pc_we: got %b want 0", bus.pc_we_o); end
      tick(0, 1);
      compared++; if (bus.state_o !== 3'd2) begin mismatched++; $display("FAIL reebreak_state: got %0d want 2", bus.state_o); end
      bus.exception_i = 8'h00;
      send(1'b1, 2'b01);
      tick(0, 1);
      send(1'b0, 2'b00);
      tick(1, 1);
      compared++; if (bus.state_o !== 3'd1) begin mismatched++; $display("FAIL resume_state: got %0d want 1", bus.state_o); end
      compared++; if (bus.instret_o !== DW'(exp_instret)) begin mismatched++; $display("FAIL ebreak_instret: got %0d want %0d", bus.instret_o, exp_instret); end
      compared++; if (bus.cycle_cnt_o !== DW'(exp_cycle)) begin mismatched++; $display("FAIL ebreak_cycle: got %0d want %0d", bus.cycle_cnt_o, exp_cycle); end
   endtask

   task automatic test_halt_step();
      send(1'b1, 2'b10);
      tick(1, 1);
      compared++; if (bus.state_o !== 3'd2) begin mismatched++; $display("FAIL dbg_halt_state: got %0d want 2", bus.state_o); end
      compared++; if (bus.cause_o !== 8'h80) begin mismatched++; $display("FAIL dbg_halt_cause: got %h want 80", bus.cause_o); end
      send(1'b1, 2'b11);
      tick(0, 1);
      send(1'b0, 2'b00);
      compared++; if (bus.state_o !== 3'd4) begin mismatched++; $display("FAIL step_state: got %0d want 4", bus.state_o); end
      #1;
      compared++; if (bus.pc_we_o !== 1'b1) begin mismatched++; $display("FAIL step_pc_we: got %b want 1", bus.pc_we_o); end
      compared++; if (bus.cmd_ready_o !== 1'b0) begin mismatched++; $display("FAIL step_ready: got %b want 0", bus.cmd_ready_o); end
      tick(1, 1);
      compared++; if (bus.state_o !== 3'd2) begin mismatched++; $display("FAIL step_done_state: got %0d want 2", bus.state_o); end
      compared++; if (bus.cause_o !== 8'h40) begin mismatched++; $display("FAIL step_done_cause: got %h want 40", bus.cause_o); end
      compared++; if (bus.instret_o !== DW'(exp_instret)) begin mismatched++; $display("FAIL step_instret: got %0d want %0d", bus.instret_o, exp_instret); end
      // Step onto an ECALL: no skip pending, so the trap is reported.
      send(1'b1, 2'b11);
      tick(0, 1);
      send(1'b0, 2'b00);
      bus.exception_i = 8'h08;
      #1;
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL step_ecall_pc_we: got %b want 0", bus.pc_we_o); end
      tick(0, 1);
      compared++; if (bus.cause_o !== 8'h08) begin mismatched++; $display("FAIL step_ecall_cause: got %h want 08", bus.cause_o); end
      // Step again: the latched ECALL is skipped, step completes normally.
      bus.exception_i = 8'h00;
      send(1'b1, 2'b11);
      tick(0, 1);
      send(1'b0, 2'b00);
      bus.exception_i = 8'h08;
      #1;
      compared++; if (bus.pc_we_o !== 1'b1) begin mismatched++; $display("FAIL step_skip_pc_we: got %b want 1", bus.pc_we_o); end
      tick(1, 1);
      compared++; if (bus.cause_o !== 8'h40) begin mismatched++; $display("FAIL step_skip_cause: got %h want 40", bus.cause_o); end
      bus.exception_i = 8'h00;
      send(1'b1, 2'b01);
      tick(0, 1);
      send(1'b0, 2'b00);
      compared++; if (bus.state_o !== 3'd1) begin mismatched++; $display("FAIL step_run_state: got %0d want 1", bus.state_o); end
      compared++; if (bus.cycle_cnt_o !== DW'(exp_cycle)) begin mismatched++; $display("FAIL step_cycle: got %0d want %0d", bus.cycle_cnt_o, exp_cycle); end
   endtask

   task automatic test_reset_in_step();
      send(1'b1, 2'b10);
      tick(1, 1);
      send(1'b1, 2'b11);
      tick(0, 1);
      send(1'b0, 2'b00);
      compared++; if (bus.state_o !== 3'd4) begin mismatched++; $display("FAIL pre_rst_state: got %0d want 4", bus.state_o); end
      #2 rst_ni = 1'b0;
      #1;
      compared++; if (bus.state_o !== 3'd0) begin mismatched++; $display("FAIL async_rst_state: got %0d want 0", bus.state_o); end
      compared++; if (bus.cycle_cnt_o !== 64'd0) begin mismatched++; $display("FAIL async_rst_cycle: got %0d want 0", bus.cycle_cnt_o); end
      compared++; if (bus.instret_o !== 64'd0) begin mismatched++; $display("FAIL async_rst_instret: got %0d want 0", bus.instret_o); end
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL async_rst_pc_we: got %b want 0", bus.pc_we_o); end
      compared++; if (bus.cause_o !== 8'h00) begin mismatched++; $display("FAIL async_rst_cause: got %h want 00", bus.cause_o); end
      @(negedge clk) rst_ni = 1'b1;
      exp_cycle = 0; exp_instret = 0;
      tick(0, 0);
      tick(0, 0);
      compared++; if (bus.state_o !== 3'd1) begin mismatched++; $display("FAIL rerun_state: got %0d want 1", bus.state_o); end
   endtask

   task automatic test_fault_error();
      bus.exception_i = 8'h02;
      send(1'b1, 2'b10);
      #1;
      compared++; if (bus.cmd_ready_o !== 1'b1) begin mismatched++; $display("FAIL fault_ready: got %b want 1", bus.cmd_ready_o); end
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL fault_pc_we: got %b want 0", bus.pc_we_o); end
      tick(0, 1);
      compared++; if (bus.state_o !== 3'd3) begin mismatched++; $display("FAIL fault_state: got %0d want 3", bus.state_o); end
      compared++; if (bus.cause_o !== 8'h02) begin mismatched++; $display("FAIL fault_cause: got %h want 02", bus.cause_o); end
      bus.exception_i = 8'h00;
      send(1'b1, 2'b01);
      #1;
      compared++; if (bus.cmd_ready_o !== 1'b0) begin mismatched++; $display("FAIL error_ready: got %b want 0", bus.cmd_ready_o); end
      compared++; if (bus.pc_we_o !== 1'b0) begin mismatched++; $display("FAIL error_pc_we: got %b want 0", bus.pc_we_o); end
      tick(0, 1);
      tick(0, 1);
      send(1'b0, 2'b00);
      compared++; if (bus.state_o !== 3'd3) begin mismatched++; $display("FAIL error_sticky: got %0d want 3", bus.state_o); end
      compared++; if (bus.cause_o !== 8'h02) begin mismatched++; $display("FAIL error_cause_held: got %h want 02", bus.cause_o); end
      compared++; if (bus.cycle_cnt_o !== DW'(exp_cycle)) begin mismatched++; $display("FAIL error_cycle: got %0d want %0d", bus.cycle_cnt_o, exp_cycle); end
      rst_ni = 1'b0;
      #1;
      compared++; if (bus.state_o !== 3'd0) begin mismatched++; $display("FAIL error_rst_state: got %0d want 0", bus.state_o); end
      @(negedge clk) rst_ni = 1'b1;
      exp_cycle = 0; exp_instret = 0;
      tick(0, 0);
      tick(0, 0);
      compared++; if (bus.state_o !== 3'd1) begin mismatched++; $display("FAIL error_exit_state: got %0d want 1", bus.state_o); end
   endtask

   task automatic test_wrap();
      force dut.cycle_cnt = '1;
      force dut.instret   = '1;
      #1;
      release dut.cycle_cnt;
      release dut.instret;
      tick(1, 1);
      compared++; if (bus.cycle_cnt_o !== 64'd0) begin mismatched++; $display("FAIL wrap_cycle: got %h want 0", bus.cycle_cnt_o); end
      compared++; if (bus.instret_o !== 64'd0) begin mismatched++; $display("FAIL wrap_instret: got %h want 0", bus.instret_o); end
   endtask

   initial begin
      compared        = 0;
      mismatched      = 0;
      exp_cycle       = 0;
      exp_instret     = 0;
      bus.exception_i = 8'h00;
      bus.cmd_valid_i = 1'b0;
      bus.cmd_i       = 2'b00;
      test_reset();
      test_ebreak();
      test_halt_step();
      test_reset_in_step();
      test_fault_error();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/run_ctrl.md
Name: run_ctrl

Overview:
Run-control sequencer for the single-cycle RV64I core. It replaces the inline monitor-state logic in the top level. It gates PC writeback from the CPU's exception vector and from a debug command channel (run/halt/step). It also latches the halt/error cause for the Display block, and keeps cycle and retired-instruction counters.

Parameters:
DATA_WIDTH, 64, width of cycle_cnt_o and instret_o
RST_HOLD, 2, cycles spent in RST after reset release before entering NORMAL (>=1)

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
exception_i  input  8  CPU exception vector; [2:0] fault bits, [3] ECALL, [4] EBREAK, [7:5] ignored
cmd_valid_i  input  1  debug command valid
cmd_i  input  2  00 NOP, 01 RUN, 10 HALT, 11 STEP
cmd_ready_o  output  1  command accepted when cmd_valid_i & cmd_ready_o
pc_we_o  output  1  PC write enable (combinational)
state_o  output  3  RST=0, NORMAL=1, HALT=2, ERROR=3, STEP=4
cause_o  output  8  latched cause; 8'h80 = debug halt, 8'h40 = step done, else exception_i & 8'h1F
cycle_cnt_o  output  DATA_WIDTH  cycles since leaving RST
instret_o  output  DATA_WIDTH  count of cycles with pc_we_o=1

Behaviour:
- Reset (rst_ni=0, async, any time incl. mid-STEP):
  - state=RST, hold counter=RST_HOLD-1, cause_o=0, cycle_cnt_o=0, instret_o=0, skip flag=0.
  - Outputs take reset values immediately, no clock needed.
- Decoded inputs: fault = |exception_i[2:0]; trap = exception_i[3] | exception_i[4]. Priority: fault > trap > command.
- pc_we_o = (state==NORMAL | state==STEP) & ~fault & (~trap | skip).
- cmd_ready_o = 1 in NORMAL and HALT; 0 in RST, STEP and ERROR. Commands are not queued. When ready=0, the requester holds valid.
- RST:
  - hold counter decrements each cycle; when it is 0, next state is NORMAL.
  - pc_we_o=0; counters frozen.
- NORMAL:
  - fault -> ERROR; cause <= exception_i & 8'h1F.
  - else trap & ~skip -> HALT; cause <= exception_i & 8'h1F.
  - else an accepted HALT -> HALT; cause <= 8'h80.
  - RUN, STEP and NOP are consumed as no-ops.
  - If an exception and a HALT command arrive in the same cycle, the exception cause wins and the command is still consumed (ready was 1).
- HALT:
  - exception_i is ignored; pc_we_o=0.
  - Accepted RUN -> NORMAL; cause <= 0.
  - Accepted STEP -> STEP.
  - HALT and NOP are no-ops.
  - On leaving HALT via RUN or STEP, skip <= 1 if the latched cause has bit3 or bit4 set; otherwise skip <= 0.
- skip:
  - Masks trap for exactly one PC-writing cycle, so execution resumes past the ECALL/EBREAK.
  - Clears after the first cycle spent in NORMAL or STEP.
  - Faults are never masked.
- STEP:
  - Lasts one cycle, then always goes to HALT.
  - cause <= fault or unmasked trap ? (exception_i & 8'h1F) : 8'h40.
- ERROR:
  - Sticky until reset. pc_we_o=0, commands not accepted, cause held.
- Counters:
  - cycle_cnt_o increments every cycle state != RST.
  - instret_o increments on every cycle with pc_we_o=1.
  - Both wrap modulo 2^DATA_WIDTH with no saturation.
- Registered state transitions: an event at edge N is visible on state_o after edge N.

Test Plan:
- Reset release, RST_HOLD=2, exception_i=0 -> state_o is 0 for 2 cycles, then 1; pc_we_o=1 from the first NORMAL cycle; instret_o=1 after one NORMAL edge.
- NORMAL, exception_i=8'h10 (EBREAK) for one cycle -> pc_we_o=0 that cycle, state_o=2, cause_o=8'h10; then cmd RUN -> state_o=1, pc_we_o=1 on the first cycle despite exception_i=8'h10, cause_o=0, next cycle with 8'h10 halts again.
- NORMAL, exception_i=8'h02 together with cmd HALT -> state_o=3, cause_o=8'h02, cmd consumed; a later RUN sees cmd_ready_o=0 and state stays 3 until rst_ni pulse.
- NORMAL cmd HALT -> state_o=2, cause_o=8'h80; cmd STEP -> one cycle state_o=4 with pc_we_o=1, instret_o +1, then state_o=2, cause_o=8'h40.
- Assert rst_ni=0 between clock edges while in STEP -> state_o=0, counters 0, pc_we_o=0 immediately.
- Preload counters via force to all-ones, run one NORMAL cycle -> both wrap to 0.
